wb_sequencer: RTL
=================

# wb_sequencer

Controls the MEM→WB boundary of the five-stage MIPS pipeline when data memory has variable latency. It issues load/store requests to data memory with a req/ack handshake and stalls the upstream pipeline while a request is outstanding. It registers the writeback result and drives the Mem-vs-ALU select, so the register file sees exactly one write per retiring instruction.

## Interface
Parameters:
- TIMEOUT, 16: maximum wait cycles for mem_ack before the access is abandoned (2..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_valid  in  1  MEM stage holds a valid instruction.
- m_load  in  1  MEM instruction is a load.
- m_store  in  1  MEM instruction is a store.
- m_regwrite  in  1  MEM instruction writes a GPR.
- m_wa  in  5  destination GPR.
- m_alu  in  32  ALU result / memory address.
- mem_ack  in  1  data memory completes the current access.
- mem_rdata  in  32  load data, valid with mem_ack.
- mem_req  out  1  access request.
- mem_we  out  1  store qualifier, valid with mem_req.
- stall  out  1  freeze PC, F/D, D/E, E/M registers this cycle.
- wb_we  out  1  register-file write enable.
- wb_wa  out  5  register-file write address.
- wb_wdata  out  32  register-file write data.
- wb_memtoreg  out  1  current WB data came from memory (for forwarding logic).
- bus_err  out  1  sticky timeout flag.

## Operation
- States: IDLE, WAIT.
- IDLE with m_valid & (m_load | m_store):
  - mem_req = 1 combinationally; mem_we = m_store.
  - If mem_ack is high in the same cycle, the access completes with no stall.
  - Otherwise go to WAIT with stall = 1.
- IDLE with any other m_valid instruction: retire directly. Source is ALU; no request.
- WAIT:
  - mem_req and stall are held at 1.
  - Wait counter increments each cycle.
  - mem_ack completes the access, deasserts stall combinationally in that cycle, and returns to IDLE.
- Timeout: when the counter reaches TIMEOUT-1 in WAIT with no ack:
  - bus_err is set (sticky until reset).
  - The access retires with write suppressed.
  - Returns to IDLE.
- Retire: on the completing edge, the WB registers load:
  - wb_we = m_regwrite & (m_wa != 0) & !timeout.
  - wb_wa = m_wa.
  - wb_memtoreg = m_load.
  - wb_wdata = m_load ? mem_rdata : m_alu.
- Non-retire cycles (stall, !m_valid): wb_we = 0 next cycle (bubble). wb_wa, wb_wdata and wb_memtoreg hold.
- mem_ack outside a request is ignored.
- Stores never write a GPR, even if m_regwrite is 1.
- Upstream guarantees MEM inputs are stable while stall = 1. The block never re-issues a request for the same instruction.

## Timing
- Reset values: state IDLE, counter 0, mem_req 0, mem_we 0, stall 0, wb_we 0, wb_wa 0, wb_wdata 0, wb_memtoreg 0, bus_err 0.
- ALU instruction: WB outputs valid 1 cycle after it sits in MEM.
- Load/store with ack on cycle k of request (k = 0 is first req cycle):
  - stall is high for k cycles.
  - WB is valid at cycle k+1.
- Timeout: stall is high for exactly TIMEOUT cycles. bus_err rises on the edge ending the last one.
- Async reset in WAIT: mem_req and stall drop immediately; no writeback occurs.
- Back-to-back loads: the second mem_req asserts in the cycle after the first ack, with no idle gap.

## Structure
- Shared package: state encoding (IDLE = 0, WAIT = 1) and the data width constant (32).
- Submodule wb_data_mux: 32-bit 2:1 select of mem_rdata/m_alu by load flag, instantiated once ahead of the wb_wdata register.
- Remaining logic lives in one file: FSM, counter, WB registers.

## Test plan
- ALU add, m_wa = 5, m_alu = 0x0000_0010 → next cycle wb_we = 1, wb_wa = 5, wb_wdata = 0x10, wb_memtoreg = 0, stall never high.
- Load with mem_ack tied high, mem_rdata = 0xDEAD_BEEF, m_wa = 8 → no stall; next cycle wb_wdata = 0xDEADBEEF, wb_memtoreg = 1.
- Load with ack after 3 wait cycles → stall high 3 cycles, wb_we low during them, single write one cycle after ack.
- Store with ack after 1 cycle, m_regwrite = 1 → mem_we = 1 with req, stall 1 cycle, wb_we stays 0.
- No ack, TIMEOUT = 4 → stall high 4 cycles, bus_err = 1 afterward and stays, no GPR write. Then a load with m_wa = 0 → wb_we = 0.
- rst_n pulled low during WAIT cycle 2 → mem_req, stall, wb_we = 0 immediately. After release, the FSM is in IDLE and the next load issues normally.

Source files
------------

// File: rtl/wb_sequencer_pkg.sv
// Shared types and widths for the MEM->WB sequencer: FSM encoding, counter width, WB payload.
package wb_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } seq_state_e;

    // Register-file write port payload as held in the WB register
    typedef struct packed {
        logic              we;
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wdata;
        logic              memtoreg;
    } wb_pkt_t;

endpackage

// File: rtl/wb_sequencer_if.sv
// MEM-stage inputs, data-memory handshake and register-file write port of the sequencer.
interface wb_sequencer_if;
    import wb_sequencer_pkg::*;

    logic              m_valid;
    logic              m_load;
    logic              m_store;
    logic              m_regwrite;
    logic [REG_AW-1:0] m_wa;
    logic [DATA_W-1:0] m_alu;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_req;
    logic              mem_we;
    logic              stall;
    logic              wb_we;
    logic [REG_AW-1:0] wb_wa;
    logic [DATA_W-1:0] wb_wdata;
    logic              wb_memtoreg;
    logic              bus_err;

    modport slave (
        input  m_valid, m_load, m_store, m_regwrite, m_wa, m_alu, mem_ack, mem_rdata,
        output mem_req, mem_we, stall, wb_we, wb_wa, wb_wdata, wb_memtoreg, bus_err
    );

    modport master (
        output m_valid, m_load, m_store, m_regwrite, m_wa, m_alu, mem_ack, mem_rdata,
        input  mem_req, mem_we, stall, wb_we, wb_wa, wb_wdata, wb_memtoreg, bus_err
    );

endinterface

// File: rtl/wb_sequencer_data_mux.sv
// Writeback data select: load data from memory, otherwise the ALU result.
module wb_data_mux
    import wb_sequencer_pkg::*;
(
    input  logic              sel_mem,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    output logic [DATA_W-1:0] wdata_c
);

    assign wdata_c = sel_mem ? mem_data : alu_data;

endmodule

// File: rtl/wb_sequencer.sv
// MEM->WB sequencer: issues variable-latency memory accesses, stalls upstream while
// one is outstanding, and registers exactly one writeback per retiring instruction.
module wb_sequencer
    import wb_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic           clk,
    input  logic           rst_n,
    wb_sequencer_if.slave  bus
);

    seq_state_e        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              active;
    logic              is_mem;
    logic              retire;
    logic              tmo;
    logic              req_c;
    logic              we_c;
    logic              stall_c;
    logic [DATA_W-1:0] wdata_c;
    wb_pkt_t           wb_q, wb_d;
    logic              bus_err_q;

    // Gating with rst_n keeps the handshake quiet while reset is held
    assign active = bus.m_valid & rst_n;
    assign is_mem = bus.m_load | bus.m_store;

    wb_data_mux u_data_mux (
        .sel_mem  (bus.m_load),
        .mem_data (bus.mem_rdata),
        .alu_data (bus.m_alu),
        .wdata_c  (wdata_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt tracks the request cycle index: 0 is the IDLE issue cycle, WAIT starts at 1
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        req_c     = 1'b0;
        we_c      = 1'b0;
        stall_c   = 1'b0;
        retire    = 1'b0;
        tmo       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (active && is_mem) begin
                    req_c = 1'b1;
                    we_c  = bus.m_store;
                    if (bus.mem_ack) begin
                        retire = 1'b1;
                    end else begin
                        stall_c   = 1'b1;
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_W'(1);
                    end
                end else if (active) begin
                    retire = 1'b1;
                end
            end
            S_WAIT: begin
                req_c   = 1'b1;
                we_c    = bus.m_store;
                stall_c = 1'b1;
                cnt_nxt = cnt + CNT_W'(1);
                if (bus.mem_ack) begin
                    stall_c   = 1'b0;
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    retire    = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = S_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stores and r0 destinations never produce a GPR write
    always_comb begin
        wb_d.we       = bus.m_regwrite & ~bus.m_store & (bus.m_wa != '0) & ~tmo;
        wb_d.wa       = bus.m_wa;
        wb_d.wdata    = wdata_c;
        wb_d.memtoreg = bus.m_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (retire) begin
                wb_q <= wb_d;
            end else begin
                wb_q.we <= 1'b0;
            end
            if (tmo) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus.mem_req     = req_c;
    assign bus.mem_we      = we_c;
    assign bus.stall       = stall_c;
    assign bus.wb_we       = wb_q.we;
    assign bus.wb_wa       = wb_q.wa;
    assign bus.wb_wdata    = wb_q.wdata;
    assign bus.wb_memtoreg = wb_q.memtoreg;
    assign bus.bus_err     = bus_err_q;

endmodule
